// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Timing defaults assume the 100 MHz system clock.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    WAIT_FIRST,
    SEND,
    WAIT_ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;

  localparam int DEF_INHIBIT_CYCLES    = 12000;
  localparam int DEF_RTS_CYCLES        = 500;
  localparam int DEF_FIRST_CLK_TIMEOUT = 1500000;
  localparam int DEF_XFER_TIMEOUT      = 200000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake and status between a controller and ps2_host_tx.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output tx_valid, tx_data, input tx_ready, busy, done, err);
  modport slave  (input tx_valid, tx_data, output tx_ready, busy, done, err);

endinterface

// File: rtl/ps2_host_tx_line_filter.sv
// Synchronises one raw PS/2 line, debounces it over 4 samples and flags
// each falling edge of the debounced level for exactly one cycle.
module ps2_line_filter
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic       sync1;
  logic       sync2;
  logic [3:0] hist;

  // The level only moves once four consecutive samples agree; the edge flag
  // is raised in the same cycle the level drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 4'hF;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync1 <= line_in;
      sync2 <= sync1;
      hist  <= {hist[2:0], sync2};
      fall  <= 1'b0;
      if (hist == 4'hF) begin
        level <= 1'b1;
      end else if (hist == 4'h0) begin
        level <= 1'b0;
        fall  <= level;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked-out
// frame (data LSB-first, odd parity, stop) and device acknowledge.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES    = DEF_INHIBIT_CYCLES,
  parameter int RTS_CYCLES        = DEF_RTS_CYCLES,
  parameter int FIRST_CLK_TIMEOUT = DEF_FIRST_CLK_TIMEOUT,
  parameter int XFER_TIMEOUT      = DEF_XFER_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int MAX_CYCLES = max_int(max_int(INHIBIT_CYCLES, RTS_CYCLES),
                                      max_int(FIRST_CLK_TIMEOUT, XFER_TIMEOUT));
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] RTS_LAST     = CW'(RTS_CYCLES - 1);
  localparam logic [CW-1:0] FIRST_LAST   = CW'(FIRST_CLK_TIMEOUT - 1);
  localparam logic [CW-1:0] XFER_LAST    = CW'(XFER_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX      = '1;
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  ps2_state_e    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    bit_idx;
  logic [9:0]    frame;
  logic          done_q;
  logic          err_q;

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic data_fall_unused;

  ps2_line_filter u_clk_filter (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_clk_in),
    .level   (clk_level),
    .fall    (clk_fall)
  );

  ps2_line_filter u_data_filter (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_data_in),
    .level   (data_level),
    .fall    (data_fall_unused)
  );

  assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign tx.tx_ready = (state == IDLE);
  assign tx.busy     = (state != IDLE);
  assign tx.done     = done_q;
  assign tx.err      = err_q;

  // The frame register shifts right on every device clock edge and refills
  // with ones, so the stop bit falls out naturally as the tenth bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      frame       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          cnt         <= '0;
          bit_idx     <= '0;
          if (tx.tx_valid) begin
            frame      <= {1'b1, odd_parity(tx.tx_data), tx.tx_data};
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INHIBIT_LAST) begin
            cnt         <= '0;
            ps2_data_oe <= 1'b1;
            state       <= RTS;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RTS: begin
          if (cnt == RTS_LAST) begin
            cnt        <= '0;
            ps2_clk_oe <= 1'b0;
            state      <= WAIT_FIRST;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_FIRST: begin
          if (clk_fall) begin
            cnt         <= '0;
            ps2_data_oe <= ~frame[0];
            frame       <= {1'b1, frame[9:1]};
            bit_idx     <= 4'd1;
            state       <= SEND;
          end else if (cnt == FIRST_LAST) begin
            cnt         <= '0;
            ps2_data_oe <= 1'b0;
            err_q       <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        SEND, WAIT_ACK, WAIT_IDLE: begin
          cnt <= cnt_inc;
          if (cnt == XFER_LAST) begin
            cnt         <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            err_q       <= 1'b1;
            state       <= IDLE;
          end else if (state == SEND) begin
            if (clk_fall) begin
              ps2_data_oe <= ~frame[0];
              frame       <= {1'b1, frame[9:1]};
              bit_idx     <= bit_idx + 4'd1;
              if (bit_idx == 4'd9) begin
                state <= WAIT_ACK;
              end
            end
          end else if (state == WAIT_ACK) begin
            if (clk_fall) begin
              if (data_level) begin
                err_q <= 1'b1;
                state <= IDLE;
              end else begin
                state <= WAIT_IDLE;
              end
            end
          end else if (clk_level && data_level) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, 12000, clock-low inhibit time (120 us at 100 MHz) SHALL be honoured.
REQ-002 Parameter RTS_CYCLES, 500, time both lines are held low before the clock is released, SHALL be honoured.
REQ-003 Parameter FIRST_CLK_TIMEOUT, 1500000, maximum wait for the first device clock falling edge (15 ms), SHALL be honoured.
REQ-004 Parameter XFER_TIMEOUT, 200000, maximum time from first falling edge to ack (2 ms), SHALL be honoured.
REQ-005 clk  in  1  100 MHz system clock (clk100MHz domain); the only clock.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 tx_valid  in  1  command byte request.
REQ-008 tx_data  in  8  command byte (e.g. F4h enable reporting).
REQ-009 tx_ready  out  1  high only in IDLE; handshake accepted when tx_valid && tx_ready.
REQ-010 busy  out  1  high in every state except IDLE; used to gate the mouse receiver.
REQ-011 done  out  1  one-cycle pulse: byte acknowledged by the device.
REQ-012 err  out  1  one-cycle pulse: NACK or timeout.
REQ-013 ps2_clk_in, ps2_data_in  in  1 each  raw line levels (asynchronous).
REQ-014 ps2_clk_oe, ps2_data_oe  out  1 each  1 = drive line low; 0 = release (the top-level open-drain buffer drives the inout pads).

Function
REQ-015 Each input line SHALL pass a 2-FF synchroniser plus a 4-sample stability filter; a falling edge of the filtered ps2_clk SHALL be flagged for exactly one cycle.
REQ-016 On handshake, tx_data SHALL be latched and odd parity computed (parity = ~^tx_data); the FSM SHALL enter INHIBIT on the next cycle.
REQ-017 States: IDLE, INHIBIT, RTS, WAIT_FIRST, SEND, WAIT_ACK, WAIT_IDLE.
REQ-018 INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then RTS.
REQ-019 RTS: clk_oe=1, data_oe=1 (start bit) for RTS_CYCLES cycles, then WAIT_FIRST.
REQ-020 WAIT_FIRST: clk_oe=0, data_oe=1; the first falling edge SHALL enter SEND and drive bit 0.
REQ-021 SEND: each falling edge SHALL advance a 4-bit index; the line SHALL carry data[0..7] LSB-first, then parity, then stop (released). data_oe = ~bit and SHALL change only in the cycle after the edge flag.
REQ-022 On the 10th falling edge (stop bit driven, data_oe=0), the FSM SHALL enter WAIT_ACK.
REQ-023 WAIT_ACK: on the 11th falling edge, filtered data=0 SHALL mean ACK (go to WAIT_IDLE) and data=1 SHALL mean NACK (err pulse, go to IDLE).
REQ-024 WAIT_IDLE: when both filtered lines are high, the block SHALL pulse done and return to IDLE.
REQ-025 Timeouts: counter expiry in WAIT_FIRST, or expiry of XFER_TIMEOUT across SEND/WAIT_ACK/WAIT_IDLE, SHALL pulse err, release both lines and return to IDLE.
REQ-026 In every error exit, the next state SHALL be IDLE with both oe at 0; no retry is made internally.
REQ-027 tx_valid while busy SHALL be ignored and SHALL NOT corrupt the latched byte.
REQ-028 done and err SHALL never assert in the same cycle.
REQ-029 Cycle counter width SHALL be $clog2 of the maximum timeout parameter; the counter SHALL saturate and never wrap.

Reset
REQ-030 With rst=0 at a rising clk edge, the next state SHALL be IDLE, with ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, err=0, counters and bit index 0, and filters preset high.
REQ-031 Reset mid-transfer SHALL release both lines within one cycle and SHALL produce no done or err pulse.

Structure
REQ-032 Package ps2_pkg SHALL hold the state enum, command constants (F4h enable, FFh reset, F3h set sample rate) and default timing constants.
REQ-033 Sub-module ps2_line_filter SHALL contain the synchroniser, filter and falling-edge detect; it is instantiated twice.

Verification
REQ-034 Send F4h with a device model clocking at 12.5 kHz and ACK: data line bits observed 0,0,1,0,1,1,1,1, parity 0, stop 1; done pulses once; err never pulses.
REQ-035 Send 00h: parity bit = 1; the model holds data high on the 11th edge -> err pulse, no done, IDLE with both oe=0.
REQ-036 Device never clocks: err exactly FIRST_CLK_TIMEOUT cycles after WAIT_FIRST entry; both lines released.
REQ-037 Timing check: clk_oe=1 for exactly 12000 cycles with data_oe=0, then 500 cycles with both oe=1, then clk_oe=0 with data_oe=1.
REQ-038 rst=0 asserted after the 4th falling edge -> next cycle both oe=0, tx_ready=1, no done/err; a following F4h completes normally.
REQ-039 tx_valid with tx_data=FFh held during an F4h transfer is ignored: the transmitted byte is F4h, then FFh is accepted after done.
